cl_pcis_wr_stream: RTL
======================

CL_PCIS_WR_STREAM -- requirements
Module: cl_pcis_wr_stream

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO depth in beats (power of 2, >=2).
REQ-002 The block SHALL have parameter DATA_W, default 512, meaning beat width in bits.
REQ-003 The block SHALL have parameter ID_W, default 6, meaning AXI ID width.
REQ-004 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 The block SHALL have port rst_n, input, 1, the reset; reset is asynchronous and active-low.
REQ-006 The block SHALL have ports awvalid in 1, awid in ID_W, awlen in 8, awsize in 3 and awready out 1, forming the AXI4 write-address channel from the PCIS register slice.
REQ-007 The block SHALL have ports wvalid in 1, wdata in DATA_W, wstrb in DATA_W/8, wlast in 1 and wready out 1, forming the AXI4 write-data channel.
REQ-008 The block SHALL have ports bvalid out 1, bid out ID_W, bresp out 2 and bready in 1, forming the AXI4 write-response channel.
REQ-009 The block SHALL have ports m_tvalid out 1, m_tdata out DATA_W, m_tlast out 1 and m_tready in 1, forming the output stream to downstream logic.
REQ-010 The block SHALL have port fifo_cnt, output, $clog2(DEPTH)+1 bits, giving the current FIFO occupancy.

Function
REQ-011 The FSM SHALL have three states: IDLE, DATA and RESP.
REQ-012 In IDLE:
- awready SHALL be 1, wready 0 and bvalid 0.
- On awvalid&&awready the block SHALL latch awid, awlen and awsize, clear beat_cnt to 0 and the error flag, and enter DATA on the next cycle.
REQ-013 In DATA:
- wready SHALL equal !full, driven combinationally from registered occupancy.
- awready SHALL be 0.
REQ-014 Each accepted beat (wvalid&&wready) SHALL be pushed into the FIFO as {wdata, tlast}, with tlast = (beat_cnt==awlen_q); beat_cnt SHALL then increment by 1 (8-bit).
REQ-015 The burst SHALL end on the accepted beat where beat_cnt==awlen_q; the block SHALL enter RESP on the next cycle regardless of wlast.
REQ-016 The error flag SHALL be set in any of these cases, with the beat still pushed:
- an accepted beat has wlast != (beat_cnt==awlen_q);
- awsize_q != 3'b110.
REQ-017 wstrb SHALL be ignored for storage; every beat is stored in full.
REQ-018 In RESP:
- bvalid SHALL be 1, bid SHALL equal awid_q, and bresp SHALL be 2'b10 (SLVERR) if the error flag is set, otherwise 2'b00.
- bvalid and bid/bresp SHALL hold until bready, then the block SHALL return to IDLE on the next cycle.
- wready and awready SHALL be 0.
REQ-019 The FIFO SHALL be registered storage of DEPTH entries with wrapping read and write pointers.
- m_tvalid SHALL equal !empty.
- m_tdata and m_tlast SHALL present the head entry.
- The head entry SHALL be popped on m_tvalid&&m_tready.
REQ-020 Latency: a beat accepted in cycle N into an empty FIFO SHALL appear on m_tvalid in cycle N+1.
REQ-021 Simultaneous push and pop SHALL leave fifo_cnt unchanged.
REQ-022 When full, no push SHALL occur (wready=0), and the FIFO SHALL NOT bypass a push into a pop in the same cycle.
REQ-023 Pops SHALL proceed in every FSM state, independent of the AXI channels.
REQ-024 fifo_cnt SHALL range 0..DEPTH and SHALL never overflow or underflow.
REQ-025 Only one write burst SHALL be outstanding; a new AW SHALL NOT be accepted until the previous B handshake completes.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously force:
- state=IDLE;
- awready=0, wready=0, bvalid=0;
- bresp=0, bid=0;
- m_tvalid=0, fifo_cnt=0;
- pointers=0, beat_cnt=0, error flag=0.
REQ-027 awready SHALL first be 1 in the cycle after rst_n deasserts.
REQ-028 Reset asserted mid-burst SHALL discard all FIFO contents and the partial burst, and SHALL NOT issue a B response.
REQ-029 FIFO data storage SHALL NOT require reset.

Verification
REQ-030 Single-beat test: awlen=0, awid=6'h2A, awsize=6, one beat with wlast=1, m_tready=1 -> m_tvalid with m_tlast=1 one cycle after accept; bvalid with bid=6'h2A, bresp=0.
REQ-031 Backpressure test: awlen=19, m_tready=0 -> wready drops after 16 accepted beats and fifo_cnt=16; after m_tready=1 all 20 beats are output in order, with m_tlast only on beat 20 and bresp=0.
REQ-032 Protocol-error test: awlen=3 with wlast asserted on beat 2 -> 4 beats pushed, m_tlast on beat 4, bresp=2'b10; a second test with awsize=5 -> bresp=2'b10.
REQ-033 Response-stall test: bready held 0 for 10 cycles -> bvalid, bid and bresp stable; awready=0 throughout; a new AW is accepted only after the B handshake.
REQ-034 Reset-mid-operation test: assert rst_n=0 after beat 5 of an awlen=7 burst -> fifo_cnt=0, m_tvalid=0, bvalid=0 immediately; after release a fresh awlen=0 burst completes normally.
REQ-035 Push-pop test: at fifo_cnt=16 with m_tready=1 and wvalid=1 -> one pop per cycle, wready=0 in the full cycle, and fifo_cnt never exceeds 16.

Source files
------------

// File: rtl/cl_pcis_wr_stream.sv
// PCIS AXI4 write slave that turns one write burst at a time into an output stream.
// Beats are buffered in a FIFO, and the write response reports any burst-length or size error.
module cl_pcis_wr_stream #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ID_W   = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  // write address
  input  logic                awvalid,
  input  logic [ID_W-1:0]     awid,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  output logic                awready,
  // write data
  input  logic                wvalid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                wready,
  // write response
  output logic                bvalid,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  input  logic                bready,
  // output stream
  output logic                m_tvalid,
  output logic [DATA_W-1:0]   m_tdata,
  output logic                m_tlast,
  input  logic                m_tready,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

  state_e              state_q;
  logic [ID_W-1:0]     awid_q;
  logic [7:0]          awlen_q;
  logic [2:0]          awsize_q;
  logic [7:0]          beat_cnt_q;
  logic                err_q;
  logic                awready_q;
  logic                bvalid_q;
  logic [ID_W-1:0]     bid_q;
  logic [1:0]          bresp_q;

  logic [DATA_W:0]     mem [DEPTH];
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [CW-1:0]       cnt_q;

  logic full, empty, push, pop, beat_last, beat_err;
  logic [DATA_W:0] head;

  // Strobes are deliberately ignored: every beat is stored whole.
  logic unused_wstrb;
  assign unused_wstrb = ^wstrb;

  assign full      = (cnt_q == FullCnt);
  assign empty     = (cnt_q == '0);
  assign wready    = (state_q == StData) && !full;
  assign push      = wvalid && wready;
  assign pop       = !empty && m_tready;
  assign beat_last = (beat_cnt_q == awlen_q);
  assign beat_err  = (wlast != beat_last) || (awsize_q != 3'b110);

  assign awready  = awready_q;
  assign bvalid   = bvalid_q;
  assign bid      = bid_q;
  assign bresp    = bresp_q;
  assign head     = mem[rptr_q];
  assign m_tvalid = !empty;
  assign m_tdata  = head[DATA_W:1];
  assign m_tlast  = head[0];
  assign fifo_cnt = cnt_q;

  // awready is registered so it stays low through reset and rises on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      awid_q     <= '0;
      awlen_q    <= '0;
      awsize_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          awready_q <= 1'b1;
          if (awvalid && awready_q) begin
            awid_q     <= awid;
            awlen_q    <= awlen;
            awsize_q   <= awsize;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            awready_q  <= 1'b0;
            state_q    <= StData;
          end
        end
        StData: begin
          if (push) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            err_q      <= err_q | beat_err;
            if (beat_last) begin
              bvalid_q <= 1'b1;
              bid_q    <= awid_q;
              bresp_q  <= (err_q || beat_err) ? 2'b10 : 2'b00;
              state_q  <= StResp;
            end
          end
        end
        StResp: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= {wdata, beat_last};
  end

endmodule
